// File: rtl/gen3_scr_pkg.sv
// Shared constants and types for the PCIe Gen3 128b/130b lane scrambler.
//   LFSR_W / LFSR_TAPS : 23-bit Galois LFSR, x^23+x^21+x^16+x^8+x^5+x^2+1
//   LANE_SEEDS         : per-lane seed, indexed by lane mod 8
//   SYNC_DATA/SYNC_OS  : 130b block sync headers
//   os_type_e          : ordered-set kind carried with the first beat of an OS block
//   blk_state_e        : block-type FSM states
package gen3_scr_pkg;

  localparam int unsigned LFSR_W = 23;

  // Feedback taps for x^21, x^16, x^8, x^5, x^2 and x^0 (x^23 is the shift-out bit).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 23'h210125;

  localparam logic [7:0][LFSR_W-1:0] LANE_SEEDS = {
    23'h1BB807, 23'h0277CE, 23'h19CFC9, 23'h010F12,
    23'h18C0DB, 23'h1EC760, 23'h0607BB, 23'h1DBFBC
  };

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;

  typedef enum logic [1:0] {
    OS_OTHER = 2'd0,
    OS_SKP   = 2'd1,
    OS_EIEOS = 2'd2
  } os_type_e;

  typedef enum logic [2:0] {
    BLK_START = 3'd0,
    DATA      = 3'd1,
    OS        = 3'd2,
    SKP       = 3'd3,
    EIEOS     = 3'd4
  } blk_state_e;

  // Seed for a given lane; lanes beyond 7 reuse the table.
  function automatic logic [LFSR_W-1:0] lane_seed(input int unsigned lane);
    return LANE_SEEDS[3'(lane % 8)];
  endfunction

endpackage

// File: rtl/gen3_lane_scrambler_if.sv
// Stream interface of the Gen3 lane scrambler.
//   master : block framer side (drives input beats, consumes output beats)
//   slave  : scrambler side
// Signals: in_valid_i/in_ready_o/in_data_i/in_sync_hdr_i/in_os_type_i (input stream),
//          out_valid_o/out_ready_i/out_data_o/out_sync_hdr_o/out_block_start_o (output stream),
//          lfsr_state_o (per-lane LFSR state, lane 0 in LSBs).
// Optional: scr_bypass_i when GEN3_SCRAMBLE_BYPASS_EN is defined.
interface gen3_lane_scrambler_if
  import gen3_scr_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned BYTES_PER_LANE = 2
);

  localparam int unsigned DATA_W = NUM_LANES * BYTES_PER_LANE * 8;

  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [DATA_W-1:0]           in_data_i;
  logic [1:0]                  in_sync_hdr_i;
  logic [1:0]                  in_os_type_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [DATA_W-1:0]           out_data_o;
  logic [1:0]                  out_sync_hdr_o;
  logic                        out_block_start_o;
  logic [NUM_LANES*LFSR_W-1:0] lfsr_state_o;
`ifdef GEN3_SCRAMBLE_BYPASS_EN
  logic                        scr_bypass_i;
`endif

  modport master (
    output in_valid_i, in_data_i, in_sync_hdr_i, in_os_type_i, out_ready_i,
`ifdef GEN3_SCRAMBLE_BYPASS_EN
    output scr_bypass_i,
`endif
    input  in_ready_o, out_valid_o, out_data_o, out_sync_hdr_o, out_block_start_o,
           lfsr_state_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_sync_hdr_i, in_os_type_i, out_ready_i,
`ifdef GEN3_SCRAMBLE_BYPASS_EN
    input  scr_bypass_i,
`endif
    output in_ready_o, out_valid_o, out_data_o, out_sync_hdr_o, out_block_start_o,
           lfsr_state_o
  );

endinterface

// File: rtl/gen3_lfsr_symbol_step.sv
// One-symbol step of the Gen3 scrambler LFSR (combinational).
//   lfsr        : LFSR state before this symbol
//   data        : symbol to scramble, consumed LSB first
//   scramble_en : XOR the keystream into the symbol
//   advance_en  : advance the LFSR by 8 bits (otherwise hold)
//   lfsr_next   : LFSR state after this symbol
//   result      : output symbol
module gen3_lfsr_symbol_step
  import gen3_scr_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr,
  input  logic [7:0]        data,
  input  logic              scramble_en,
  input  logic              advance_en,
  output logic [LFSR_W-1:0] lfsr_next,
  output logic [7:0]        result
);

  // Walk 8 Galois shifts; keystream bit is the MSB before each shift.
  always_comb begin
    logic [LFSR_W-1:0] walk;
    logic [7:0]        key;
    walk = lfsr;
    key  = '0;
    for (int b = 0; b < 8; b++) begin
      key[b] = walk[LFSR_W-1];
      walk   = {walk[LFSR_W-2:0], 1'b0} ^ (walk[LFSR_W-1] ? LFSR_TAPS : '0);
    end
    lfsr_next = advance_en  ? walk         : lfsr;
    result    = scramble_en ? (data ^ key) : data;
  end

endmodule

// File: rtl/gen3_lane_scrambler.sv
// Multi-lane PCIe Gen3 128b/130b transmit scrambler (block framer -> gearbox).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : input beat stream with sync header / OS type on the first beat,
//                   registered output beat stream, per-lane LFSR state
// One register stage; in_ready_o = !out_valid_o | out_ready_i.
// Block types: data scrambled, OS symbol 0 plain, SKP frozen, EIEOS reseeds at block end.
// Optional build macro GEN3_SCRAMBLE_BYPASS_EN adds bus.scr_bypass_i (data passes
// through unscrambled while the LFSRs keep their normal sequence).
module gen3_lane_scrambler
  import gen3_scr_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned BYTES_PER_LANE = 2
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  gen3_lane_scrambler_if.slave bus
);

  localparam int unsigned SYMS   = NUM_LANES * BYTES_PER_LANE;
  localparam int unsigned DATA_W = SYMS * 8;
  localparam int unsigned BPB    = 16 / BYTES_PER_LANE;
  localparam int unsigned CNT_W  = (BPB > 1) ? $clog2(BPB) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BPB - 1);

  blk_state_e state_q, state_d, cur_type;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [NUM_LANES-1:0][LFSR_W-1:0] lfsr_q, lfsr_d, lane_next;
  logic [DATA_W-1:0] scr_data;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic [1:0]        out_sync_hdr_q;
  logic              out_block_start_q;

  logic in_ready, accept, first_beat, last_beat;
  logic adv_beat, os_sym0_plain, bypass;

  assign in_ready   = !out_valid_q || bus.out_ready_i;
  assign accept     = bus.in_valid_i && in_ready;
  assign first_beat = (state_q == BLK_START);
  assign last_beat  = (beat_cnt_q == LAST_BEAT);

`ifdef GEN3_SCRAMBLE_BYPASS_EN
  assign bypass = bus.scr_bypass_i;
`else
  assign bypass = 1'b0;
`endif

  // Block type governing the current beat; the first beat uses the freshly decoded header.
  always_comb begin
    cur_type = state_q;
    if (state_q == BLK_START) begin
      if (bus.in_sync_hdr_i == SYNC_OS) begin
        case (bus.in_os_type_i)
          OS_SKP:   cur_type = SKP;
          OS_EIEOS: cur_type = EIEOS;
          default:  cur_type = OS;
        endcase
      end else begin
        // 2'b10 and the illegal headers 00/11 are all handled as data.
        cur_type = DATA;
      end
    end
  end

  assign adv_beat      = (cur_type == DATA) || (cur_type == OS);
  assign os_sym0_plain = (cur_type == OS) && (beat_cnt_q == '0);

  // Per-lane chain of symbol steps; symbols within a lane consume the keystream in order.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar b = 0; b < BYTES_PER_LANE; b++) begin : g_sym
      localparam int unsigned IDX       = l * BYTES_PER_LANE + b;
      localparam bit          FIRST_SYM = (b == 0);
      logic [LFSR_W-1:0] lfsr_in, lfsr_out;
      logic              scr_en;

      if (b == 0) begin : g_head
        assign lfsr_in = lfsr_q[l];
      end else begin : g_link
        assign lfsr_in = g_sym[b-1].lfsr_out;
      end

      // OS symbol 0 goes out plain but still consumes keystream.
      assign scr_en = adv_beat && !bypass && !(FIRST_SYM && os_sym0_plain);

      gen3_lfsr_symbol_step u_step (
        .lfsr        (lfsr_in),
        .data        (bus.in_data_i[IDX*8 +: 8]),
        .scramble_en (scr_en),
        .advance_en  (adv_beat),
        .lfsr_next   (lfsr_out),
        .result      (scr_data[IDX*8 +: 8])
      );
    end
    assign lane_next[l] = g_sym[BYTES_PER_LANE-1].lfsr_out;
  end

  // LFSR next state: only moves on an accepted beat; EIEOS reloads seeds on its last beat.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        lfsr_d[l] = (cur_type == EIEOS && last_beat) ? lane_seed(l) : lane_next[l];
      end
    end
  end

  // Block FSM next state and beat counter.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      if (last_beat) begin
        state_d    = BLK_START;
        beat_cnt_d = '0;
      end else begin
        state_d    = cur_type;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // Block FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BLK_START;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // LFSR registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        lfsr_q[l] <= lane_seed(l);
      end
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Output stage: load on accept, clear valid on drain, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q       <= 1'b0;
      out_data_q        <= '0;
      out_sync_hdr_q    <= 2'b00;
      out_block_start_q <= 1'b0;
    end else if (accept) begin
      out_valid_q       <= 1'b1;
      out_data_q        <= bypass ? bus.in_data_i : scr_data;
      out_sync_hdr_q    <= first_beat ? bus.in_sync_hdr_i : 2'b00;
      out_block_start_q <= first_beat;
    end else if (bus.out_ready_i) begin
      out_valid_q       <= 1'b0;
    end
  end

  assign bus.in_ready_o        = in_ready;
  assign bus.out_valid_o       = out_valid_q;
  assign bus.out_data_o        = out_data_q;
  assign bus.out_sync_hdr_o    = out_sync_hdr_q;
  assign bus.out_block_start_o = out_block_start_q;
  assign bus.lfsr_state_o      = lfsr_q;

endmodule

// File: tb/tb_gen3_lane_scrambler.sv
// Self-checking bench for gen3_lane_scrambler: block-level reference model feeding an
// expected-beat queue, with an independent output monitor.
module tb_gen3_lane_scrambler;

  localparam int unsigned NL  = 4;
  localparam int unsigned BPL = 2;
  localparam int unsigned BPB = 16 / BPL;
  localparam int unsigned DW  = NL * BPL * 8;
  localparam int unsigned LW  = NL * 23;

  localparam int K_DATA  = 0;
  localparam int K_OS    = 1;
  localparam int K_SKP   = 2;
  localparam int K_EIEOS = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    hdr;
    logic          bs;
    logic [LW-1:0] lfsr;
  } exp_t;

  logic clk;
  logic rst_n;

  gen3_lane_scrambler_if #(.NUM_LANES(NL), .BYTES_PER_LANE(BPL)) bus ();

  gen3_lane_scrambler #(.NUM_LANES(NL), .BYTES_PER_LANE(BPL)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

`ifdef GEN3_SCRAMBLE_BYPASS_EN
  initial bus.scr_bypass_i = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic [22:0] m_lfsr [NL];
  logic [22:0] seeds [8];
  int   stall_cnt = 0;
  bit   rand_ready = 0;

  // Polynomial arithmetic: multiply state by x modulo x^23+x^21+x^16+x^8+x^5+x^2+1.
  function automatic logic [22:0] mulx(input logic [22:0] s);
    logic [23:0] t;
    t = {s, 1'b0};
    if (t[23]) t = t ^ 24'hA10125;
    return t[22:0];
  endfunction

  function automatic logic [7:0] key_byte(input logic [22:0] s);
    logic [22:0] t;
    logic [7:0]  k;
    t = s;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = t[22];
      t = mulx(t);
    end
    return k;
  endfunction

  function automatic logic [22:0] adv8(input logic [22:0] s);
    logic [22:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = mulx(t);
    return t;
  endfunction

  function automatic logic [LW-1:0] seed_vec();
    logic [LW-1:0] v;
    for (int l = 0; l < NL; l++) v[l*23 +: 23] = seeds[l % 8];
    return v;
  endfunction

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Out-ready driver: forced stalls, then random or always-ready.
  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        bus.out_ready_i = 1'b0;
        stall_cnt--;
      end else if (rand_ready) begin
        bus.out_ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready_i = 1'b1;
      end
    end
  end

  // Monitor: checks held beats stay stable, compares each drained beat against the queue.
  initial begin
    bit            hold;
    logic [DW-1:0] p_data;
    logic [1:0]    p_hdr;
    logic          p_bs;
    logic [LW-1:0] p_lfsr;
    exp_t          e;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("hold_data", 128'(bus.out_data_o), 128'(p_data));
          check("hold_lfsr", 128'(bus.lfsr_state_o), 128'(p_lfsr));
          check("hold_ctl", 128'({bus.out_sync_hdr_o, bus.out_block_start_o}),
                128'({p_hdr, p_bs}));
        end
        if (bus.out_valid_o && !bus.out_ready_i)
          check("stall_in_ready", 128'(bus.in_ready_o), 128'(0));
        hold   = bus.out_valid_o && !bus.out_ready_i;
        p_data = bus.out_data_o;
        p_hdr  = bus.out_sync_hdr_o;
        p_bs   = bus.out_block_start_o;
        p_lfsr = bus.lfsr_state_o;
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (q.size() == 0) begin
            check("unexpected_beat", 128'(1), 128'(0));
          end else begin
            e = q.pop_front();
            check("out_data", 128'(bus.out_data_o), 128'(e.data));
            check("out_ctl", 128'({bus.out_sync_hdr_o, bus.out_block_start_o}),
                  128'({e.hdr, e.bs}));
            check("lfsr_state", 128'(bus.lfsr_state_o), 128'(e.lfsr));
          end
        end
      end
    end
  end

  // Build one block from the block-type rules, then drive nsend beats of it.
  // fill_mode 0: every symbol = fillv; 1: random symbols.
  // stall_at >= 0 forces a 5-cycle out_ready drop when that beat is presented.
  // If nsend < BPB, beat nsend is left presented (valid) on return.
  task automatic run_block(input logic [1:0] hdr, input logic [1:0] ost, input int fill_mode,
                           input logic [7:0] fillv, input int nsend, input int stall_at);
    logic [7:0]  blk [NL][16];
    logic [22:0] lf [NL];
    exp_t        exps [BPB];
    int          kind;
    int          s;
    bit          acc;
    int          t;
    logic [7:0]  d;

    if (hdr == 2'b01) kind = (ost == 2'd1) ? K_SKP : (ost == 2'd2) ? K_EIEOS : K_OS;
    else              kind = K_DATA;

    for (int l = 0; l < NL; l++) begin
      lf[l] = m_lfsr[l];
      for (int i = 0; i < 16; i++) blk[l][i] = fill_mode ? 8'($urandom) : fillv;
    end

    for (int k = 0; k < int'(BPB); k++) begin
      for (int l = 0; l < NL; l++) begin
        for (int b = 0; b < int'(BPL); b++) begin
          s = k * BPL + b;
          d = blk[l][s];
          if (kind == K_DATA || kind == K_OS) begin
            if (!(kind == K_OS && s == 0)) d = d ^ key_byte(lf[l]);
            lf[l] = adv8(lf[l]);
          end
          exps[k].data[(l*BPL+b)*8 +: 8] = d;
        end
      end
      if (kind == K_EIEOS && k == int'(BPB) - 1)
        for (int l = 0; l < NL; l++) lf[l] = seeds[l % 8];
      exps[k].hdr = (k == 0) ? hdr : 2'b00;
      exps[k].bs  = (k == 0);
      for (int l = 0; l < NL; l++) exps[k].lfsr[l*23 +: 23] = lf[l];
    end

    for (int k = 0; k <= nsend && k < int'(BPB); k++) begin
      for (int l = 0; l < NL; l++)
        for (int b = 0; b < int'(BPL); b++)
          bus.in_data_i[(l*BPL+b)*8 +: 8] = blk[l][k*BPL+b];
      bus.in_sync_hdr_i = (k == 0) ? hdr : 2'($urandom);
      bus.in_os_type_i  = (k == 0) ? ost : 2'($urandom);
      bus.in_valid_i    = 1'b1;
      if (k == stall_at) stall_cnt = 5;
      if (k == nsend) return;
      t = 0;
      acc = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = bus.in_ready_o;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        check("accept_timeout", 128'(0), 128'(1));
        finish_run();
      end
      q.push_back(exps[k]);
    end
    bus.in_valid_i = 1'b0;
    if (nsend >= int'(BPB))
      for (int l = 0; l < NL; l++) m_lfsr[l] = lf[l];
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.out_valid_o) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) check("drain_timeout", 128'(q.size()), 128'(0));
  endtask

  initial begin
    seeds = '{23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
              23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807};
    for (int l = 0; l < NL; l++) m_lfsr[l] = seeds[l % 8];
    rst_n             = 1'b0;
    bus.in_valid_i    = 1'b0;
    bus.in_data_i     = '0;
    bus.in_sync_hdr_i = 2'b00;
    bus.in_os_type_i  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
    check("rst_out_data", 128'(bus.out_data_o), 128'(0));
    check("rst_out_ctl", 128'({bus.out_sync_hdr_o, bus.out_block_start_o}), 128'(0));
    check("rst_lfsr", 128'(bus.lfsr_state_o), 128'(seed_vec()));
    check("rst_in_ready", 128'(bus.in_ready_o), 128'(1));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero data block: output is the raw keystream.
    run_block(2'b10, 2'd0, 0, 8'h00, BPB, -1);
    // SKP block of 0xAA: passes unchanged, LFSR frozen.
    run_block(2'b01, 2'd1, 0, 8'hAA, BPB, -1);
    // EIEOS then data: every lane restarts from its seed.
    run_block(2'b01, 2'd2, 1, 8'h00, BPB, -1);
    drain();
    check("eieos_reseed", 128'(bus.lfsr_state_o), 128'(seed_vec()));
    run_block(2'b10, 2'd0, 1, 8'h00, BPB, -1);
    // OS block of 0x2D: symbol 0 plain, rest scrambled.
    run_block(2'b01, 2'd0, 0, 8'h2D, BPB, -1);
    drain();

    // Backpressure: forced stall mid-block, then random ready.
    run_block(2'b10, 2'd0, 1, 8'h00, BPB, 3);
    rand_ready = 1;
    for (int i = 0; i < 24; i++)
      run_block(2'($urandom), 2'($urandom), 1, 8'h00, BPB, (i % 5 == 0) ? 2 : -1);
    rand_ready = 0;
    drain();

    // Reset with beat 3 of a data block presented.
    run_block(2'b10, 2'd0, 1, 8'h00, 3, -1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(bus.out_valid_o), 128'(0));
    check("mid_rst_data", 128'(bus.out_data_o), 128'(0));
    check("mid_rst_ctl", 128'({bus.out_sync_hdr_o, bus.out_block_start_o}), 128'(0));
    check("mid_rst_lfsr", 128'(bus.lfsr_state_o), 128'(seed_vec()));
    bus.in_valid_i = 1'b0;
    q.delete();
    for (int l = 0; l < NL; l++) m_lfsr[l] = seeds[l % 8];
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // First beat after reset must be decoded as a block start.
    run_block(2'b01, 2'd1, 0, 8'hAA, BPB, -1);
    run_block(2'b10, 2'd0, 1, 8'h00, BPB, -1);
    drain();
    check("final_queue_empty", 128'(q.size()), 128'(0));
    finish_run();
  end

endmodule

// File: doc/gen3_lane_scrambler.md
Name: gen3_lane_scrambler

Overview:
- Multi-lane PCIe Gen3 128b/130b transmit scrambler in phy_transmit, between the block framer and the gearbox.
- Holds one registered 23-bit LFSR per lane, XORs data symbols with the keystream, and applies block-type rules:
  - data blocks scrambled;
  - SKP blocks frozen;
  - EIEOS reseeds the LFSR.
- Stream in and out use valid/ready handshakes; all lanes are block-aligned.

Parameters:
- NUM_LANES, 4, lane count (1..16)
- BYTES_PER_LANE, 2, symbols per lane per beat (1, 2, 4 or 8; must divide 16)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid&ready
- in_data_i  in  NUM_LANES*BYTES_PER_LANE*8  lane-major symbols, lane0 in LSBs
- in_sync_hdr_i  in  2  block sync header; sampled on the first beat of a block only
- in_os_type_i  in  2  on the first beat: 0 other OS, 1 SKP, 2 EIEOS; ignored for data blocks
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  NUM_LANES*BYTES_PER_LANE*8  scrambled symbols
- out_sync_hdr_o  out  2  sync header, forwarded unscrambled with the first beat
- out_block_start_o  out  1  marks the first beat of a block
- lfsr_state_o  out  NUM_LANES*23  current per-lane LFSR state, for verification

Behaviour:
- Polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, Galois form.
  - Keystream bit = lfsr[22].
  - One advance per data bit, LSB first.
  - 8 advances per symbol.
- Per-lane seeds, indexed by lane mod 8: 1DBFBC, 0607BB, 1EC760, 18C0DB, 010F12, 19CFC9, 0277CE, 1BB807 (hex, bits [22:0]).
- Reset: every LFSR = lane seed; out_valid_o=0; out_data_o=0; out_sync_hdr_o=0; out_block_start_o=0; FSM=BLK_START; beat counter=0.
- Beats per block: BPB = 16/BYTES_PER_LANE. A beat counter counts 0..BPB-1 on accepted beats and wraps to 0.
- FSM states: BLK_START, DATA, OS, SKP, EIEOS.
  - BLK_START, on an accepted beat: header 2'b10 -> DATA; header 2'b01 -> OS, SKP or EIEOS per in_os_type_i; header 00/11 -> DATA (treated as data, no error output).
  - Every block state returns to BLK_START after the beat with counter=BPB-1.
  - The first beat is processed under the newly decoded type in the same cycle.
- Symbol rules per block type:
  - DATA: all symbols scrambled; LFSR advances.
  - OS: symbol 0 of each lane is unscrambled but the LFSR advances; symbols 1..15 scrambled.
  - SKP: no scrambling; LFSR held.
  - EIEOS: no scrambling; LFSR held during the block, then loaded with the seed on the last beat.
- Pipeline: one register stage, so latency is 1 cycle from input acceptance to out_valid_o.
  - in_ready_o = !out_valid_o | out_ready_i.
  - The LFSR updates only on an accepted input beat.
  - Output registers hold stable while out_valid_o & !out_ready_i.
- Simultaneous events: capture of a new beat and drain of the held beat in one cycle is allowed, giving full throughput.
- An asynchronous reset mid-block discards the block in flight; after reset, the first beat is treated as a block start.

Optional Feature:
- Macro GEN3_SCRAMBLE_BYPASS_EN adds input scr_bypass_i (1 bit, sampled per accepted beat).
- With the macro, when scr_bypass_i=1:
  - out_data_o = in_data_i unmodified;
  - the LFSR still follows the normal advance, hold and reseed rules, so bypass can toggle on block boundaries without loss of sync.
- Without the macro the port is absent and scrambling is always active.

Decomposition:
- Package gen3_scr_pkg holds:
  - LFSR width constant (23) and polynomial tap mask;
  - seed array (8 entries);
  - sync header constants (2'b10, 2'b01);
  - os_type enum;
  - FSM state enum.
- Sub-module gen3_lfsr_symbol_step (combinational): inputs lfsr[22:0], data[7:0], scramble_en, advance_en; outputs next lfsr and the result byte.
  - Instantiated NUM_LANES*BYTES_PER_LANE times and chained within each lane.

Test Plan:
- Reset, then one data block of all-zero symbols on lane 0 -> output equals the golden-model keystream from seed 1DBFBC; lfsr_state_o lane0 equals the model after 128 advances.
- SKP block of 0xAA symbols -> output 0xAA unchanged; lfsr_state_o identical before and after the block.
- EIEOS block, then a data block -> EIEOS passes unscrambled; every lane's LFSR equals its seed at the start of the data block (lane 1 = 0607BB, lane 9 = 0607BB).
- OS block, symbols 0x2D -> symbol 0 of each lane = 0x2D; symbols 1..15 scrambled; LFSR advanced 128 bits.
- Hold out_ready_i=0 for 5 cycles mid-block -> in_ready_o=0, output stable, LFSR unchanged; on release, no beat lost or duplicated versus the model.
- Pull rst_ni low on beat 3 of a data block (BYTES_PER_LANE=2) -> outputs 0 immediately; the next beat is decoded as a block start.
